// File: rtl/disp_fetch_ctrl.sv
// Display frame-fetch AXI read-address master: walks one frame in fixed INCR bursts,
// gated by an outstanding-burst limit and pixel-FIFO credit so the FIFO never overflows.
module disp_fetch_ctrl #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int BURST_LEN          = 16,
    parameter int MAX_OUTSTANDING    = 2,
    parameter int HACTIVE            = 1024,
    parameter int VACTIVE            = 768,
    parameter int PIX_PER_BEAT       = 2,
    parameter int FIFO_DEPTH         = 512
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          DISP_ON,
    input  logic                          FRAME_START,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] DISP_ADDR,
    input  logic [$clog2(FIFO_DEPTH):0]   FIFO_WR_CNT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    input  logic                          M_AXI_RLAST,
    input  logic [1:0]                    M_AXI_RRESP,
    output logic                          FETCH_BUSY,
    output logic                          FETCH_DONE,
    output logic                          FRAME_MISS,
    output logic                          RRESP_ERR
);

    localparam int AW          = C_M_AXI_ADDR_WIDTH;
    localparam int BEAT_BYTES  = C_M_AXI_DATA_WIDTH / 8;
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int NBURST      = HACTIVE * VACTIVE / (PIX_PER_BEAT * BURST_LEN);
    localparam int ISS_W       = $clog2(NBURST + 1);
    localparam int OUT_W       = $clog2(MAX_OUTSTANDING + 1);
    localparam int RST_STAGES  = 2;
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BURST_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Reset asserts asynchronously but is released in step with ACLK.
    logic [RST_STAGES-1:0] rst_sync_q;
    logic [RST_STAGES-1:0] rst_sync_d;
    logic                  rst_n;

    assign rst_sync_d[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < RST_STAGES; gi++) begin : g_rst_sync
            assign rst_sync_d[gi] = rst_sync_q[gi-1];
        end
    endgenerate

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[RST_STAGES-1];

    state_t          state_q, state_d;
    logic            arvalid_q, arvalid_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic [ISS_W-1:0] issued_q, issued_d;
    logic [OUT_W-1:0] outst_q, outst_d;
    logic            fetch_done_q, fetch_done_d;
    logic            frame_miss_q, frame_miss_d;
    logic            rresp_err_q, rresp_err_d;

    logic            ar_hs;
    logic            r_last_ok;
    logic            frame_accept;
    logic            issue_ok;
    logic [31:0]     credit_need;

    assign ar_hs        = arvalid_q && M_AXI_ARREADY;
    assign r_last_ok    = M_AXI_RVALID && M_AXI_RLAST && (outst_q != '0);
    assign frame_accept = FRAME_START && DISP_ON && (state_q == ST_IDLE);

    // Room must exist for every burst already in flight plus the one about to be requested.
    assign credit_need = 32'(FIFO_WR_CNT) + (32'(outst_q) + 32'd1) * 32'(BURST_LEN);
    assign issue_ok    = (issued_q < ISS_W'(NBURST)) && DISP_ON &&
                         (outst_q < OUT_W'(MAX_OUTSTANDING)) &&
                         (credit_need <= 32'(FIFO_DEPTH));

    always_comb begin
        state_d      = state_q;
        arvalid_d    = 1'b0;
        araddr_d     = araddr_q;
        issued_d     = issued_q;
        outst_d      = outst_q;
        fetch_done_d = 1'b0;
        frame_miss_d = FRAME_START && !frame_accept;
        rresp_err_d  = frame_accept ? 1'b0 : rresp_err_q;

        if (M_AXI_RVALID && (M_AXI_RRESP != 2'b00)) begin
            rresp_err_d = 1'b1;
        end

        if (ar_hs) begin
            issued_d = issued_q + ISS_W'(1);
            araddr_d = araddr_q + AW'(BURST_BYTES);
        end

        case ({ar_hs, r_last_ok})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = outst_q - OUT_W'(1);
            default: outst_d = outst_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (frame_accept) begin
                    state_d  = ST_RUN;
                    araddr_d = DISP_ADDR & ALIGN_MASK;
                    issued_d = '0;
                end
            end
            ST_RUN: begin
                // A pending request is never withdrawn; a new one waits one idle cycle.
                if (arvalid_q) begin
                    arvalid_d = !M_AXI_ARREADY;
                end else begin
                    arvalid_d = issue_ok;
                end
                if ((issued_q == ISS_W'(NBURST)) || (!DISP_ON && !arvalid_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (outst_q == '0) begin
                    state_d      = ST_IDLE;
                    fetch_done_d = (issued_q == ISS_W'(NBURST));
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            issued_q     <= '0;
            outst_q      <= '0;
            fetch_done_q <= 1'b0;
            frame_miss_q <= 1'b0;
            rresp_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            issued_q     <= issued_d;
            outst_q      <= outst_d;
            fetch_done_q <= fetch_done_d;
            frame_miss_q <= frame_miss_d;
            rresp_err_q  <= rresp_err_d;
        end
    end

    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(BEAT_BYTES));
    assign M_AXI_RREADY  = 1'b1;
    assign FETCH_BUSY    = (state_q != ST_IDLE);
    assign FETCH_DONE    = fetch_done_q;
    assign FRAME_MISS    = frame_miss_q;
    assign RRESP_ERR     = rresp_err_q;

endmodule

// File: tb/tb_disp_fetch_ctrl.sv
// Bench for disp_fetch_ctrl: small 64x4 frame, spec-level cycle model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_disp_fetch_ctrl;

    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int BL  = 4;
    localparam int MO  = 2;
    localparam int HA  = 64;
    localparam int VA  = 4;
    localparam int PPB = 2;
    localparam int FD  = 16;
    localparam int CW  = $clog2(FD) + 1;
    localparam int BB  = BL * DW / 8;              // 32 bytes per burst
    localparam int NB  = HA * VA / (PPB * BL);     // 32 bursts per frame

    logic          ACLK;
    logic          ARESETN;
    logic          DISP_ON;
    logic          FRAME_START;
    logic [AW-1:0] DISP_ADDR;
    logic [CW-1:0] FIFO_WR_CNT;
    logic          ARVALID;
    logic          ARREADY;
    logic [AW-1:0] ARADDR;
    logic [7:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic          RVALID;
    logic          RREADY;
    logic          RLAST;
    logic [1:0]    RRESP;
    logic          BUSY;
    logic          DONE;
    logic          MISS;
    logic          ERR;

    disp_fetch_ctrl #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .BURST_LEN(BL),
        .MAX_OUTSTANDING(MO),
        .HACTIVE(HA),
        .VACTIVE(VA),
        .PIX_PER_BEAT(PPB),
        .FIFO_DEPTH(FD)
    ) dut (
        .ACLK(ACLK),
        .ARESETN(ARESETN),
        .DISP_ON(DISP_ON),
        .FRAME_START(FRAME_START),
        .DISP_ADDR(DISP_ADDR),
        .FIFO_WR_CNT(FIFO_WR_CNT),
        .M_AXI_ARVALID(ARVALID),
        .M_AXI_ARREADY(ARREADY),
        .M_AXI_ARADDR(ARADDR),
        .M_AXI_ARLEN(ARLEN),
        .M_AXI_ARSIZE(ARSIZE),
        .M_AXI_RVALID(RVALID),
        .M_AXI_RREADY(RREADY),
        .M_AXI_RLAST(RLAST),
        .M_AXI_RRESP(RRESP),
        .FETCH_BUSY(BUSY),
        .FETCH_DONE(DONE),
        .FRAME_MISS(MISS),
        .RRESP_ERR(ERR)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus-to-slave controls
    bit chk_en   = 1'b0;
    bit ar_block = 1'b0;
    bit r_block  = 1'b0;
    int err_at   = -1;
    int gbeat    = 0;

    // Spec-level model of the controller, advanced once per clock edge.
    bit          m_busy, m_drain, m_av, m_done, m_miss, m_err;
    logic [31:0] m_addr;
    int          m_issued, m_outst, m_rst_cnt;

    logic [31:0] ar_log [0:1023];
    int          ar_total   = 0;
    int          done_total = 0;

    task automatic m_reset();
        m_busy = 0; m_drain = 0; m_av = 0; m_done = 0; m_miss = 0; m_err = 0;
        m_addr = 32'h0; m_issued = 0; m_outst = 0;
    endtask

    task automatic m_step();
        bit hs, rl, acc;
        bit n_busy, n_drain, n_av, n_done, n_miss, n_err;
        logic [31:0] n_addr;
        int n_issued, n_outst;
        hs  = m_av && ARREADY;
        rl  = RVALID && RLAST && (m_outst > 0);
        acc = FRAME_START && DISP_ON && !m_busy;
        n_miss   = FRAME_START && !acc;
        n_err    = (acc ? 1'b0 : m_err) || (RVALID && RRESP != 2'b00);
        n_outst  = m_outst + (hs ? 1 : 0) - (rl ? 1 : 0);
        n_issued = m_issued + (hs ? 1 : 0);
        n_addr   = hs ? m_addr + 32'(BB) : m_addr;
        n_busy   = m_busy;
        n_drain  = m_drain;
        n_av     = 0;
        n_done   = 0;
        if (!m_busy) begin
            if (acc) begin
                n_busy   = 1;
                n_drain  = 0;
                n_addr   = DISP_ADDR & ~32'(BB - 1);
                n_issued = 0;
            end
        end else if (!m_drain) begin
            if (m_av) n_av = !ARREADY;
            else      n_av = (m_issued < NB) && DISP_ON && (m_outst < MO) &&
                             (int'(FIFO_WR_CNT) + (m_outst + 1) * BL <= FD);
            if (m_issued == NB || (!DISP_ON && !m_av)) n_drain = 1;
        end else if (m_outst == 0) begin
            n_busy  = 0;
            n_drain = 0;
            n_done  = (m_issued == NB);
        end
        m_busy = n_busy; m_drain = n_drain; m_av = n_av; m_done = n_done;
        m_miss = n_miss; m_err = n_err; m_addr = n_addr;
        m_issued = n_issued; m_outst = n_outst;
    endtask

    // Compare process: every falling edge, outputs versus model.
    initial begin
        m_reset();
        m_rst_cnt = 2;
        forever begin
            @(negedge ACLK);
            if (chk_en) begin
                if (!ARESETN) begin
                    m_reset();
                    m_rst_cnt = 2;
                end
                chk("arvalid",   ARVALID, m_av);
                chk("araddr",    ARADDR,  m_addr);
                chk("arlen",     ARLEN,   BL - 1);
                chk("arsize",    ARSIZE,  3);
                chk("rready",    RREADY,  1);
                chk("busy",      BUSY,    m_busy);
                chk("done",      DONE,    m_done);
                chk("miss",      MISS,    m_miss);
                chk("rresp_err", ERR,     m_err);
                if (ARESETN) begin
                    if (ARVALID && ARREADY) begin
                        if (ar_total < 1024) ar_log[ar_total] = ARADDR;
                        $display("AR #%0d addr=0x%08h", ar_total, ARADDR);
                        ar_total++;
                    end
                    if (DONE) done_total++;
                    if (m_rst_cnt > 0) m_rst_cnt--;
                    else m_step();
                end
            end
        end
    end

    // AXI read slave: ARREADY gated by ar_block, R bursts returned in order.
    initial begin
        int pending;
        int sbeat;
        bit hs_seen;
        bit r_taken;
        pending = 0; sbeat = 0;
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
        forever begin
            @(negedge ACLK);
            hs_seen = ARESETN && ARVALID && ARREADY;
            r_taken = RVALID && RREADY;
            @(posedge ACLK);
            #1;
            if (!ARESETN) begin
                pending = 0; sbeat = 0;
                RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
                ARREADY = !ar_block;
            end else begin
                if (hs_seen) pending++;
                if (r_taken) begin
                    gbeat++;
                    if (RLAST) begin
                        pending--;
                        sbeat = 0;
                    end else begin
                        sbeat++;
                    end
                end
                ARREADY = !ar_block;
                if (pending > 0 && !r_block) begin
                    RVALID = 1'b1;
                    RLAST  = (sbeat == BL - 1);
                    RRESP  = (gbeat == err_at) ? 2'b10 : 2'b00;
                end else begin
                    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #2;
        end
    endtask

    task automatic pulse_start();
        FRAME_START = 1'b1;
        tick(1);
        FRAME_START = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int c;
        c = 0;
        while (BUSY && c < limit) begin
            tick(1);
            c++;
        end
        chk(name, BUSY, 0);
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, done0, n_ar, c, breaks;
        logic [31:0] held;
        ARESETN = 1'b0; DISP_ON = 1'b0; FRAME_START = 1'b0;
        DISP_ADDR = 32'h0; FIFO_WR_CNT = '0;
        tick(3);
        chk_en = 1'b1;
        tick(1);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_araddr",  ARADDR,  0);
        chk("rst_rready",  RREADY,  1);
        chk("rst_busy",    BUSY,    0);
        chk("rst_err",     ERR,     0);
        ARESETN = 1'b1;
        tick(4);

        // Full frame, zero-wait slave, with a FRAME_START arriving mid-frame
        DISP_ON = 1'b1; DISP_ADDR = 32'h1000_0000;
        base = ar_total; done0 = done_total;
        pulse_start();
        chk("lat_c1_arvalid", ARVALID, 0);
        chk("lat_c1_busy",    BUSY,    1);
        tick(1);
        chk("lat_c2_arvalid", ARVALID, 1);
        chk("lat_c2_araddr",  ARADDR,  32'h1000_0000);
        tick(10);
        pulse_start();
        chk("miss_in_run", MISS, 1);
        wait_idle(400, "s1_idle");
        chk("s1_ar_count", ar_total - base, 32);
        chk("s1_first",    ar_log[base], 32'h1000_0000);
        chk("s1_last",     ar_log[base + 31], 32'h1000_03E0);
        breaks = 0;
        for (int i = 1; i < 32; i++)
            if (ar_log[base + i] != ar_log[base + i - 1] + 32'h20) breaks++;
        chk("s1_seq_breaks", breaks, 0);
        chk("s1_done", done_total - done0, 1);

        // FRAME_START while display is off
        DISP_ON = 1'b0;
        pulse_start();
        chk("miss_idle",       MISS, 1);
        chk("miss_idle_busy",  BUSY, 0);
        tick(1);
        chk("miss_one_cycle",  MISS, 0);

        // Credit gating (R data held back so outstanding stays put)
        DISP_ON = 1'b1; FIFO_WR_CNT = CW'(13); r_block = 1'b1;
        base = ar_total; done0 = done_total;
        pulse_start();
        tick(12);
        chk("credit13_no_ar",   ar_total - base, 0);
        chk("credit13_arvalid", ARVALID, 0);
        FIFO_WR_CNT = CW'(12);
        tick(12);
        chk("credit12_one_ar",  ar_total - base, 1);
        FIFO_WR_CNT = CW'(9);
        tick(8);
        chk("credit9_still_one", ar_total - base, 1);
        r_block = 1'b0;
        tick(20);
        FIFO_WR_CNT = '0;
        wait_idle(600, "s3_idle");
        chk("s3_ar_count", ar_total - base, 32);
        chk("s3_done",     done_total - done0, 1);

        // Abort: ARREADY stalled while DISP_ON falls
        DISP_ADDR = 32'h1000_0000;
        base = ar_total; done0 = done_total;
        pulse_start();
        tick(8);
        ar_block = 1'b1;
        c = 0;
        while (!(ARVALID && !ARREADY) && c < 30) begin
            tick(1);
            c++;
        end
        chk("abort_stall_seen", ARVALID, 1);
        DISP_ON = 1'b0;
        held = ARADDR;
        n_ar = ar_total;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("abort_hold_valid", ARVALID, 1);
            chk("abort_hold_addr",  ARADDR,  held);
        end
        ar_block = 1'b0;
        wait_idle(100, "abort_idle");
        chk("abort_one_more_ar", ar_total - n_ar, 1);
        chk("abort_last_addr",   ar_log[ar_total - 1], held);
        chk("abort_partial",     (ar_total - base) < 32, 1);
        chk("abort_no_done",     done_total - done0, 0);

        // Read error on beat 7 of the frame
        DISP_ON = 1'b1;
        err_at = gbeat + 7;
        done0 = done_total;
        pulse_start();
        wait_idle(400, "err_idle");
        chk("err_frame_done",  done_total - done0, 1);
        chk("err_sticky_done", ERR, 1);
        err_at = -1;
        DISP_ADDR = 32'h1000_0000;
        pulse_start();
        chk("err_cleared", ERR, 0);

        // Reset while two bursts are outstanding
        r_block = 1'b1;
        c = 0;
        while (m_outst != 2 && c < 50) begin
            tick(1);
            c++;
        end
        chk("rst_pre_busy", BUSY, 1);
        ARESETN = 1'b0;
        #1;
        chk("rst_now_arvalid", ARVALID, 0);
        chk("rst_now_busy",    BUSY,    0);
        chk("rst_now_araddr",  ARADDR,  0);
        tick(3);
        ARESETN = 1'b1;
        r_block = 1'b0;
        tick(4);
        DISP_ADDR = 32'h2000_0045;
        base = ar_total; done0 = done_total;
        pulse_start();
        wait_idle(400, "s6_idle");
        chk("s6_ar_count", ar_total - base, 32);
        chk("s6_first",    ar_log[base], 32'h2000_0040);
        chk("s6_last",     ar_log[base + 31], 32'h2000_0420);
        chk("s6_done",     done_total - done0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
